// File: rtl/spi_txn_arbiter.sv
// Two-requester arbiter that sequences multi-byte chip-select framed transactions
// on a shared byte-level SPI engine; all outward control is registered.
module spi_txn_arbiter #(
  parameter int LEN_W    = 4,
  parameter int TIMEOUT  = 64,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic             IN_SCLK,
  input  logic             RST,
  input  logic [1:0]       REQ,
  input  logic [LEN_W-1:0] LEN0,
  input  logic [LEN_W-1:0] LEN1,
  input  logic [7:0]       TXD0,
  input  logic [7:0]       TXD1,
  output logic [1:0]       TX_POP,
  output logic [1:0]       GNT,
  output logic [7:0]       RXD,
  output logic [1:0]       RX_VLD,
  output logic [1:0]       DONE,
  output logic             ERR,
  output logic             CS_N,
  output logic             E_W_STB,
  output logic [7:0]       E_W_DATA,
  input  logic             E_W_ACK,
  input  logic             E_R_STB,
  input  logic [7:0]       E_R_DATA
);

  localparam int TMR_MAX = (TIMEOUT > CS_SETUP) ?
                           ((TIMEOUT > CS_HOLD) ? TIMEOUT : CS_HOLD) :
                           ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] ONE_BYTE   = LEN_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SEND  = 3'd2,
    WACK  = 3'd3,
    RWAIT = 3'd4,
    HOLD  = 3'd5,
    FIN   = 3'd6
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             owner;
  logic             owner_nx;
  logic             grant_id;
  logic             rr;
  logic [LEN_W-1:0] cnt;
  logic [TMR_W-1:0] tmr;
  logic             abort_q;

  logic [1:0]       own_oh;
  logic [1:0]       gnt_d;
  logic [1:0]       pop_d;
  logic [1:0]       rx_vld_d;
  logic [1:0]       done_d;
  logic             err_d;
  logic             cs_n_d;
  logic             stb_d;
  logic [7:0]       wdata_d;
  logic [7:0]       rxd_d;

  // State register plus the per-transaction counters it owns
  always_ff @(posedge IN_SCLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      owner   <= 1'b0;
      rr      <= 1'b0;
      cnt     <= '0;
      tmr     <= '0;
      abort_q <= 1'b0;
    end else begin
      state <= next_state;
      owner <= owner_nx;
      tmr   <= (next_state != state) ? '0 : tmr + TMR_W'(1);
      if (state == IDLE) begin
        cnt     <= owner_nx ? LEN1 : LEN0;
        abort_q <= 1'b0;
      end else if (state == RWAIT && E_R_STB) begin
        cnt <= cnt - ONE_BYTE;
      end
      if (state == RWAIT && !E_R_STB && tmr == TO_LAST)
        abort_q <= 1'b1;
      if (state == FIN)
        rr <= ~owner;
    end
  end

  // Next-state: a read strobe landing on the expiry cycle still wins over the abort
  always_comb begin
    next_state = state;
    owner_nx   = owner;
    grant_id   = (REQ == 2'b11) ? rr : REQ[1];
    unique case (state)
      IDLE: begin
        if (|REQ) begin
          owner_nx   = grant_id;
          next_state = (((grant_id ? LEN1 : LEN0)) == '0) ? FIN : SETUP;
        end
      end
      SETUP: if (tmr == SETUP_LAST) next_state = SEND;
      SEND:  next_state = WACK;
      WACK:  if (E_W_ACK) next_state = RWAIT;
      RWAIT: begin
        if (E_R_STB)
          next_state = (cnt == ONE_BYTE) ? HOLD : SEND;
        else if (tmr == TO_LAST)
          next_state = HOLD;
      end
      HOLD:  if (tmr == HOLD_LAST) next_state = FIN;
      FIN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registers line up with it
  always_comb begin
    own_oh   = owner_nx ? 2'b10 : 2'b01;
    gnt_d    = (next_state != IDLE) ? own_oh : 2'b00;
    cs_n_d   = !(next_state inside {SETUP, SEND, WACK, RWAIT, HOLD});
    stb_d    = (next_state == SEND);
    pop_d    = stb_d ? own_oh : 2'b00;
    done_d   = (next_state == FIN) ? own_oh : 2'b00;
    err_d    = (next_state == FIN) && (state != IDLE) && abort_q;
    wdata_d  = stb_d ? (owner_nx ? TXD1 : TXD0) : E_W_DATA;
    rx_vld_d = 2'b00;
    rxd_d    = RXD;
    if (state == RWAIT && E_R_STB) begin
      rx_vld_d = owner ? 2'b10 : 2'b01;
      rxd_d    = E_R_DATA;
    end
  end

  always_ff @(posedge IN_SCLK or negedge RST) begin
    if (!RST) begin
      GNT      <= 2'b00;
      TX_POP   <= 2'b00;
      RX_VLD   <= 2'b00;
      DONE     <= 2'b00;
      ERR      <= 1'b0;
      RXD      <= 8'h00;
      CS_N     <= 1'b1;
      E_W_STB  <= 1'b0;
      E_W_DATA <= 8'h00;
    end else begin
      GNT      <= gnt_d;
      TX_POP   <= pop_d;
      RX_VLD   <= rx_vld_d;
      DONE     <= done_d;
      ERR      <= err_d;
      RXD      <= rxd_d;
      CS_N     <= cs_n_d;
      E_W_STB  <= stb_d;
      E_W_DATA <= wdata_d;
    end
  end

endmodule
